genx_qspi_master: RTL and testbench

- QSPI initiator for the GenX register/SMEM QSPI protocol.
- Drives SCK, the 4-bit MOSI bus and the two active-low chip-selects (host, bank), and captures MISO.
- Executes one command per start pulse: 8-bit opcode, 32-bit address, then either up to 16 write words or 16 dummy clocks followed by up to 16 read words.
- Sits between a local command source (register block/AXI shim) and the external QSPI pins, and pairs with the QSPI responder.

---
 rtl/genx_qspi_master.sv | 177 +++++++++++++++++
 tb/tb_genx_qspi_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genx_qspi_master.sv
// genx_qspi_master: GenX QSPI initiator, one opcode/address/data command per start strobe.
// Optional mid-transfer abort input is enabled by defining QSPI_ABORT_EN.
module genx_qspi_master #(
  parameter int SCK_DIV     = 2,
  parameter int MAX_WORDS   = 16,
  parameter int CS_GAP_CLKS = 4
) (
  input  logic         clk,
  input  logic         resetn,
`ifdef QSPI_ABORT_EN
  input  logic         abort,
`endif
  input  logic         start,
  input  logic [7:0]   cmd_opcode,
  input  logic [31:0]  cmd_addr,
  input  logic [1:0]   cmd_cs,
  input  logic         cmd_rd,
  input  logic [4:0]   cmd_words,
  input  logic [255:0] wdata_h,
  input  logic [255:0] wdata_l,
  output logic [255:0] rdata_h,
  output logic [255:0] rdata_l,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         sck,
  output logic [3:0]   mosi,
  input  logic [3:0]   miso,
  output logic         host_csn,
  output logic         bank_csn
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SCK_HI, SCK_LO, CS_HOLD, CS_GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP_CLKS - 1);
  localparam logic [4:0]  WMAX     = 5'(MAX_WORDS);

  state_t       state;
  logic [15:0]  cnt;
  logic [9:0]   edge_cnt, total;
  logic [7:0]   op_q;
  logic [31:0]  addr_sw;
  logic [511:0] wd_q, shadow, rdata_q;
  logic         rd_q, aborted;
  logic [1:0]   csn;
  logic         abort_req, div_end;
  logic [9:0]   edge_nxt;
  logic [6:0]   rx_k;
  logic [4:0]   words_clamp;

`ifdef QSPI_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign div_end     = (cnt == DIV_LAST);
  assign edge_nxt    = edge_cnt + 10'd1;
  assign rx_k        = 7'(edge_nxt - 10'd33);
  assign words_clamp = (cmd_words > WMAX) ? WMAX : cmd_words;
  assign host_csn    = csn[0];
  assign bank_csn    = csn[1];
  assign rdata_h     = rdata_q[511:256];
  assign rdata_l     = rdata_q[255:0];

  // Nibble presented for rising edge n (1-based); read transactions send zeros after the address.
  function automatic logic [3:0] nib_at(input logic [9:0] n);
    logic [3:0] r;
    r = 4'h0;
    if (n <= 10'd8)       r = {3'b000, op_q[3'(10'd8 - n)]};
    else if (n <= 10'd16) r = addr_sw[{~3'(n - 10'd9), 2'b00} +: 4];
    else if (!rd_q)       r = wd_q[{~7'(n - 10'd17), 2'b00} +: 4];
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      total    <= '0;
      op_q     <= '0;
      addr_sw  <= '0;
      wd_q     <= '0;
      rd_q     <= 1'b0;
      aborted  <= 1'b0;
      shadow   <= '0;
      rdata_q  <= '0;
      sck      <= 1'b0;
      mosi     <= '0;
      csn      <= 2'b11;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      cnt  <= cnt + 16'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            if (cmd_cs == 2'b00) begin
              err <= 1'b1;
            end else begin
              op_q     <= cmd_opcode;
              addr_sw  <= {cmd_addr[7:0], cmd_addr[15:8], cmd_addr[23:16], cmd_addr[31:24]};
              wd_q     <= {wdata_h, wdata_l};
              rd_q     <= cmd_rd;
              total    <= cmd_rd ? 10'd32 + {2'b00, words_clamp, 3'b000}
                                 : 10'd16 + {2'b00, words_clamp, 3'b000};
              edge_cnt <= '0;
              shadow   <= '0;
              aborted  <= 1'b0;
              csn      <= ~cmd_cs;
              mosi     <= {3'b000, cmd_opcode[7]};
              busy     <= 1'b1;
              state    <= CS_SETUP;
            end
          end
        end
        CS_SETUP, SCK_LO: begin
          if (abort_req) begin
            sck     <= 1'b0;
            aborted <= 1'b1;
            cnt     <= '0;
            state   <= CS_HOLD;
          end else if (div_end) begin
            // miso is captured on the same clk edge that raises sck
            sck      <= 1'b1;
            edge_cnt <= edge_nxt;
            if (rd_q && edge_nxt >= 10'd33) shadow[{~rx_k, 2'b00} +: 4] <= miso;
            cnt      <= '0;
            state    <= SCK_HI;
          end
        end
        SCK_HI: begin
          if (abort_req) begin
            sck     <= 1'b0;
            aborted <= 1'b1;
            cnt     <= '0;
            state   <= CS_HOLD;
          end else if (div_end) begin
            sck <= 1'b0;
            cnt <= '0;
            if (edge_cnt == total) begin
              state <= CS_HOLD;
            end else begin
              mosi  <= nib_at(edge_nxt);
              state <= SCK_LO;
            end
          end
        end
        CS_HOLD: begin
          if (div_end) begin
            csn   <= 2'b11;
            mosi  <= '0;
            cnt   <= '0;
            state <= CS_GAP;
          end
        end
        CS_GAP: begin
          if (cnt == GAP_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            if (rd_q && !aborted) rdata_q <= shadow;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genx_qspi_master.sv
// Self-checking bench for genx_qspi_master: directed protocol cases plus random commands
// checked against a nibble-stream / read-data reference model and a QSPI responder model.
module tb_genx_qspi_master;
  localparam int DIV = 2;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic [7:0]   cmd_opcode = '0;
  logic [31:0]  cmd_addr = '0;
  logic [1:0]   cmd_cs = '0;
  logic         cmd_rd = 1'b0;
  logic [4:0]   cmd_words = '0;
  logic [255:0] wdata_h = '0, wdata_l = '0;
  logic [255:0] rdata_h, rdata_l;
  logic         busy, done, err, sck, host_csn, bank_csn;
  logic [3:0]   mosi;
  logic [3:0]   miso = 4'h0;
`ifdef QSPI_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  genx_qspi_master #(.SCK_DIV(DIV), .MAX_WORDS(16), .CS_GAP_CLKS(GAP)) dut (
    .clk(clk), .resetn(resetn),
`ifdef QSPI_ABORT_EN
    .abort(abort),
`endif
    .start(start), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_cs(cmd_cs),
    .cmd_rd(cmd_rd), .cmd_words(cmd_words), .wdata_h(wdata_h), .wdata_l(wdata_l),
    .rdata_h(rdata_h), .rdata_l(rdata_l), .busy(busy), .done(done), .err(err),
    .sck(sck), .mosi(mosi), .miso(miso), .host_csn(host_csn), .bank_csn(bank_csn));

  // Two extra instances only used to measure the SCK period at other dividers.
  logic [255:0] s_rh[2], s_rl[2];
  logic         s_busy[2], s_done[2], s_err[2], s_sck[2], s_hcs[2], s_bcs[2];
  logic [3:0]   s_mosi[2];

  for (genvar g = 0; g < 2; g++) begin : gs
    genx_qspi_master #(.SCK_DIV(g == 0 ? 1 : 3), .MAX_WORDS(16), .CS_GAP_CLKS(GAP)) u (
      .clk(clk), .resetn(resetn),
`ifdef QSPI_ABORT_EN
      .abort(1'b0),
`endif
      .start(start2), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_cs(cmd_cs),
      .cmd_rd(cmd_rd), .cmd_words(cmd_words), .wdata_h(wdata_h), .wdata_l(wdata_l),
      .rdata_h(s_rh[g]), .rdata_l(s_rl[g]), .busy(s_busy[g]), .done(s_done[g]), .err(s_err[g]),
      .sck(s_sck[g]), .mosi(s_mosi[g]), .miso(4'h0), .host_csn(s_hcs[g]), .bank_csn(s_bcs[g]));
    int nr = 0, c = 0, t1 = 0, t2 = 0;
    logic prev = 1'b0;
    always @(negedge clk) begin
      c++;
      if (s_sck[g] === 1'b1 && !prev) begin
        nr++;
        if (nr == 1) t1 = c;
        if (nr == 2) t2 = c;
      end
      prev = (s_sck[g] === 1'b1);
    end
  end

  int n_assert = 0, n_fail = 0;
  int edges = 0, rbase = 0, done_cnt = 0, glitch = 0, busy_done_bad = 0;
  logic [3:0]   mosi_q[$];
  logic [1:0]   csn_q[$];
  logic         sck_prev = 1'b0;
  logic [3:0]   mosi_prev = '0;
  logic [1:0]   csn_prev = 2'b11;
  logic [31:0]  resp[16];
  logic [511:0] exp_rdata = '0;

  // Responder: nibble for edge n; junk during opcode/address/dummy so capture must ignore it.
  function automatic logic [3:0] resp_nib(input int n);
    int k;
    if (n < 33) return 4'($urandom);
    k = n - 33;
    if (k >= 128) return 4'h0;
    return 4'(resp[k / 8] >> (28 - 4 * (k % 8)));
  endfunction

  always @(negedge clk) begin
    if (sck === 1'b1 && !sck_prev) begin
      edges++;
      mosi_q.push_back(mosi);
      csn_q.push_back({bank_csn, host_csn});
      if (mosi !== mosi_prev || {bank_csn, host_csn} !== csn_prev) glitch++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) busy_done_bad++;
    end
    sck_prev  = (sck === 1'b1);
    mosi_prev = mosi;
    csn_prev  = {bank_csn, host_csn};
    miso      = resp_nib(edges - rbase + 1);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] op, input logic [31:0] addr, input logic [1:0] cs,
                     input logic rd, input logic [4:0] words, input logic [511:0] wd,
                     input bit dbl, input string tag);
    logic [3:0]   exp_q[$];
    logic [31:0]  sw, word;
    int           weff, qb, db, t, nerr, cerr;
    weff = (words > 5'd16) ? 16 : int'(words);
    sw = {addr[7:0], addr[15:8], addr[23:16], addr[31:24]};
    for (int i = 0; i < 8; i++) exp_q.push_back({3'b000, op[7 - i]});
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(sw >> (28 - 4 * i)));
    if (rd) begin
      for (int i = 0; i < 16 + 8 * weff; i++) exp_q.push_back(4'h0);
    end else begin
      for (int w = 0; w < weff; w++) begin
        word = 32'(wd >> (480 - 32 * w));
        for (int i = 0; i < 8; i++) exp_q.push_back(4'(word >> (28 - 4 * i)));
      end
    end
    @(negedge clk);
    qb = mosi_q.size(); rbase = edges; db = done_cnt;
    cmd_opcode = op; cmd_addr = addr; cmd_cs = cs; cmd_rd = rd; cmd_words = words;
    wdata_h = wd[511:256]; wdata_l = wd[255:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, busy, 1);
    // inputs must be latched: scramble them for the rest of the transaction
    cmd_opcode = 8'($urandom); cmd_addr = $urandom; cmd_cs = 2'($urandom);
    cmd_rd = 1'($urandom); cmd_words = 5'($urandom);
    wdata_h = {8{$urandom}}; wdata_l = {8{$urandom}};
    t = 0;
    while (done_cnt == db && t < 3000) begin
      @(negedge clk);
      t++;
      start = (dbl && t == 40);
    end
    start = 1'b0;
    chk({tag, " done_seen"}, t < 3000, 1);
    repeat (3) @(negedge clk);
    chk({tag, " edges"}, edges - rbase, exp_q.size());
    chk({tag, " done_count"}, done_cnt - db, 1);
    nerr = 0; cerr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (qb + i >= mosi_q.size()) begin nerr++; cerr++; end
      else begin
        if (mosi_q[qb + i] !== exp_q[i]) nerr++;
        if (csn_q[qb + i] !== ~cs) cerr++;
      end
    end
    chk({tag, " mosi_stream_errs"}, nerr, 0);
    chk({tag, " csn_errs"}, cerr, 0);
    if (rd) begin
      exp_rdata = '0;
      for (int w = 0; w < weff; w++) exp_rdata = exp_rdata | ({resp[w], 480'b0} >> (32 * w));
    end
    chk({tag, " rdata"}, {rdata_h, rdata_l}, exp_rdata);
  endtask

  initial begin
    logic [511:0] wd;
    int t, db, tcs, tdone;
    for (int i = 0; i < 16; i++) resp[i] = '0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst sck", sck, 0);
    chk("rst mosi", mosi, 0);
    chk("rst csn", {bank_csn, host_csn}, 2'b11);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst rdata", {rdata_h, rdata_l}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // directed write from the plan
    wd = {32'hDEADBEEF, 32'h01020304, 448'h0};
    for (int i = 0; i < 14; i++) wd[447 - 32 * i -: 32] = $urandom;
    run(8'h5A, 32'h12345678, 2'b01, 1'b0, 5'd2, wd, 1'b0, "wr_w2");

    resp[0] = 32'hCAFEF00D;
    run(8'h0B, $urandom, 2'b10, 1'b1, 5'd1, '0, 1'b0, "rd_r1");

    for (int i = 0; i < 16; i++) resp[i] = i;
    run(8'h0B, 32'h0000_0100, 2'b01, 1'b1, 5'd16, '0, 1'b1, "rd_r16_dbl");
    chk("rd_r16 word15", rdata_l[31:0], 32'd15);

    run(8'hA5, $urandom, 2'b11, 1'b0, 5'd0, '0, 1'b0, "wr_w0");
    run(8'h03, $urandom, 2'b01, 1'b1, 5'd0, '0, 1'b0, "rd_r0");

    // rejected command: err pulse only
    @(negedge clk);
    db = done_cnt; rbase = edges;
    cmd_cs = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cs0 err", err, 1);
    chk("cs0 busy", busy, 0);
    @(negedge clk);
    chk("cs0 err_pulse", err, 0);
    repeat (10) @(negedge clk);
    chk("cs0 no_edges", edges - rbase, 0);
    chk("cs0 csn", {bank_csn, host_csn}, 2'b11);
    chk("cs0 no_done", done_cnt - db, 0);

    // reset at edge 20 of a write
    @(negedge clk);
    rbase = edges; db = done_cnt;
    cmd_opcode = 8'h5A; cmd_addr = 32'h1; cmd_cs = 2'b11; cmd_rd = 1'b0; cmd_words = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (edges - rbase < 20 && t < 2000) begin @(negedge clk); t++; end
    chk("rstmid reached_edge20", t < 2000, 1);
    resetn = 1'b0;
    #1;
    chk("rstmid sck", sck, 0);
    chk("rstmid csn", {bank_csn, host_csn}, 2'b11);
    chk("rstmid busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("rstmid no_done", done_cnt - db, 0);
    resetn = 1'b1;
    exp_rdata = '0;
    chk("rstmid rdata", {rdata_h, rdata_l}, 0);
    for (int i = 0; i < 16; i++) resp[i] = $urandom;
    run(8'hC3, $urandom, 2'b01, 1'b1, 5'd3, '0, 1'b0, "post_rst_rd");

    // SCK period at other dividers
    @(negedge clk);
    cmd_cs = 2'b01; cmd_rd = 1'b0; cmd_words = 5'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t = 0;
    while ((gs[0].nr < 2 || gs[1].nr < 2 || s_busy[0] || s_busy[1]) && t < 2000) begin
      @(negedge clk); t++;
    end
    chk("period completed", t < 2000, 1);
    chk("period div1", gs[0].t2 - gs[0].t1, 2);
    chk("period div3", gs[1].t2 - gs[1].t1, 6);

`ifdef QSPI_ABORT_EN
    // abort at edge 36 of an R=4 read: rdata must keep the previous read
    @(negedge clk);
    rbase = edges; db = done_cnt;
    cmd_opcode = 8'h0B; cmd_addr = $urandom; cmd_cs = 2'b01; cmd_rd = 1'b1; cmd_words = 5'd4;
    for (int i = 0; i < 16; i++) resp[i] = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (edges - rbase < 36 && t < 2000) begin @(negedge clk); t++; end
    chk("abort reached_edge36", t < 2000, 1);
    abort = 1'b1;
    t = 0; tcs = 0; tdone = 0;
    while (tdone == 0 && t < 100) begin
      @(negedge clk);
      abort = 1'b0;
      t++;
      if (tcs == 0 && host_csn === 1'b1 && bank_csn === 1'b1) tcs = t;
      if (done === 1'b1) tdone = t;
    end
    chk("abort csn_high_at", tcs, DIV + 1);
    chk("abort done_at", tdone, DIV + GAP + 1);
    repeat (3) @(negedge clk);
    chk("abort edges", edges - rbase, 36);
    chk("abort done_count", done_cnt - db, 1);
    chk("abort rdata_kept", {rdata_h, rdata_l}, exp_rdata);
`endif

    // random commands
    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < 16; i++) begin
        resp[i] = $urandom;
        wd[511 - 32 * i -: 32] = $urandom;
      end
      run(8'($urandom), $urandom, 2'($urandom_range(1, 3)), 1'($urandom),
          5'($urandom_range(0, 20)), wd, bit'($urandom), $sformatf("rand%0d", n));
    end

    chk("mosi_csn_stable_at_rise", glitch, 0);
    chk("busy_low_in_done_cycle", busy_done_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
